fp_mul_arbiter: RTL and testbench
=================================

Name: fp_mul_arbiter

Overview:
Shares one pipelined floating-point multiplier (registered inputs, registered outputs, common enable) between NUM_REQ requesters. Each requester uses a valid/ready handshake to issue operand pairs. The block grants round-robin and drives the multiplier operands and enable. It tracks the requester ID of each in-flight operation through a tag pipeline matched to multiplier latency, and routes each result back to its originator with backpressure. It sits between the requesting engines and the single multiplier instance, which is external to this block.

Parameters:
N, 32, operand/result width (IEEE-754 single)
NUM_REQ, 4, number of requesters (2..8)
MUL_LAT, 2, multiplier latency in enabled cycles (input reg + output reg)
TAG_W, 2, requester-ID width, must equal clog2(NUM_REQ)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_a  in  NUM_REQ*N  operand A, requester i at bits [i*N +: N]
req_b  in  NUM_REQ*N  operand B, same packing
rsp_valid  out  NUM_REQ  one-hot result valid, addressed to originating requester
rsp_ready  in  NUM_REQ  per-requester result accept
rsp_data  out  N  product, shared by all requesters
rsp_overflow  out  1  multiplier overflow flag for rsp_data
rsp_exception  out  1  multiplier exception flag for rsp_data
mul_a  out  N  to multiplier input A
mul_b  out  N  to multiplier input B
mul_en  out  1  to multiplier enable (freezes all multiplier registers when low)
mul_result  in  N  from multiplier
mul_overflow  in  1  from multiplier
mul_exception  in  1  from multiplier
busy  out  1  any operation in flight

Behaviour:
- Reset (reset=0, async): all stage valid bits = 0; round-robin pointer = 0. Outputs: req_ready=0, rsp_valid=0, mul_en=1, busy=0. mul_a, mul_b, rsp_data and flags are don't-care while their valid bit is 0. Operations in flight at reset are dropped without a response.
- Stall condition: stall = out_valid && !rsp_ready[out_tag]. mul_en = !stall. When stall=1, the tag/valid pipeline also holds.
- Arbitration, when mul_en=1 and any req_valid=1:
  - grant = first requester with req_valid=1, searching from pointer upward and wrapping modulo NUM_REQ.
  - req_ready[grant]=1; all other bits 0. req_ready is 0 during a stall.
- Issue: mul_a/mul_b = req_a/req_b of the granted requester (combinational mux). Stage-0 valid/tag capture (1, grant) on the same edge the multiplier captures its inputs. No grant means stage-0 valid = 0.
- Pointer update: on a handshake, pointer <= grant+1 modulo NUM_REQ. Without a handshake the pointer holds.
- Tag pipeline: MUL_LAT stages of {valid, tag}, shifted only when mul_en=1. The last stage gives out_valid/out_tag, aligned with mul_result.
- Response: rsp_valid = out_valid ? onehot(out_tag) : 0. rsp_data/flags pass mul_result/flags combinationally.
- Latency: handshake at edge k produces rsp_valid at cycle k+MUL_LAT, if no stall occurs. Throughput is one op per cycle.
- Simultaneous events: a response accepted and a new issue in the same cycle are legal, and full throughput is kept. A stall blocks new issue even for a requester whose own response is not the stalled one.
- A requester dropping req_valid without a handshake is allowed; no state changes.
- busy = OR of all stage valid bits.

Optional Feature:
FP_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins; the pointer register is removed.
- Undefined (default): round-robin as above.

Decomposition:
- Package fp_mul_arb_pkg holds:
  - constants DEFAULT_NUM_REQ and DEFAULT_MUL_LAT
  - typedef tag_t (TAG_W bits)
  - typedef stage_t {valid, tag}
- Sub-module rr_arbiter (NUM_REQ): takes req vector, pointer and advance; returns one-hot grant and next pointer. The FP_ARB_FIXED_PRIO_EN variant lives inside rr_arbiter.

Test Plan:
1. Requester 1 only, a=0x40000000, b=0x40400000, rsp_ready all 1 -> rsp_valid=0b0010 exactly 2 cycles after handshake, rsp_data=0x40C00000, flags 0.
2. All 4 req_valid held high for 8 cycles, rsp_ready all 1 -> grants 0,1,2,3,0,1,2,3 on consecutive cycles; responses in the same order; busy high throughout.
3. Two ops issued, then rsp_ready[0]=0 for 3 cycles while op for requester 0 is at output -> mul_en=0, req_ready=0, rsp_data stable; on release, both results delivered in order with no loss or duplicate.
4. a=b=0x7F000000 from requester 2 -> rsp_valid=0b0100 with rsp_overflow=1.
5. Assert reset with 2 ops in flight -> next cycle rsp_valid=0, busy=0, pointer 0; first post-reset grant with all valid goes to requester 0.
6. With FP_ARB_FIXED_PRIO_EN, requesters 0 and 3 valid for 3 cycles -> requester 0 granted all 3 cycles; requester 3 granted only after req_valid[0] drops.

Source files
------------

// File: rtl/fp_mul_arb_pkg.sv
// Shared constants and types for the floating-point multiplier arbiter.
package fp_mul_arb_pkg;

  localparam int unsigned DEFAULT_NUM_REQ = 4;
  localparam int unsigned DEFAULT_MUL_LAT = 2;
  localparam int unsigned DEFAULT_TAG_W   = $clog2(DEFAULT_NUM_REQ);

  typedef logic [DEFAULT_TAG_W-1:0] tag_t;

  typedef struct packed {
    logic valid;
    tag_t tag;
  } stage_t;

endpackage

// File: rtl/fp_mul_arbiter_rr.sv
// Round-robin grant selection with next-pointer computation.
// Build with FP_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   ptr_next_o
);

`ifndef FP_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0] grant_idx;

  always_comb begin
    int unsigned idx;
    logic        found;
    grant_o   = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Search upward from the pointer, wrapping modulo NUM_REQ.
      idx = int'(ptr_i) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx    = PTR_W'(idx);
      end
    end
  end

  // Kept apart from grant selection so advance_i (derived from grant_o) forms no loop.
  always_comb begin
    ptr_next_o = ptr_i;
    if (advance_i) begin
      ptr_next_o = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  logic unused_advance;
  assign unused_advance = advance_i;

  always_comb begin
    logic found;
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i]) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
      end
    end
  end

  assign ptr_next_o = ptr_i;
`endif

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one pipelined FP multiplier among NUM_REQ requesters with tag-routed responses.
// FP_ARB_FIXED_PRIO_EN selects fixed-priority arbitration and drops the pointer register.
module fp_mul_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned MUL_LAT = DEFAULT_MUL_LAT,
  parameter int unsigned TAG_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_a,
  input  logic [NUM_REQ*N-1:0] req_b,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [N-1:0]         rsp_data,
  output logic                 rsp_overflow,
  output logic                 rsp_exception,
  output logic [N-1:0]         mul_a,
  output logic [N-1:0]         mul_b,
  output logic                 mul_en,
  input  logic [N-1:0]         mul_result,
  input  logic                 mul_overflow,
  input  logic                 mul_exception,
  output logic                 busy
);

  logic [MUL_LAT-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [MUL_LAT];
  logic [TAG_W-1:0]   tag_d [MUL_LAT];
  logic               out_valid;
  logic [TAG_W-1:0]   out_tag;
  logic               stall;
  logic               handshake;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [TAG_W-1:0]   grant_idx;
  logic [TAG_W-1:0]   ptr;
  logic [TAG_W-1:0]   ptr_next;

  assign out_valid = valid_q[MUL_LAT-1];
  assign out_tag   = tag_q[MUL_LAT-1];
  assign stall     = out_valid && !rsp_ready[out_tag];
  assign mul_en    = !stall;

  // No grant while stalled or held in reset.
  assign arb_req   = (mul_en && reset) ? req_valid : '0;
  assign handshake = |grant;
  assign req_ready = grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (TAG_W)
  ) u_arb (
    .req_i      (arb_req),
    .ptr_i      (ptr),
    .advance_i  (handshake),
    .grant_o    (grant),
    .ptr_next_o (ptr_next)
  );

`ifndef FP_ARB_FIXED_PRIO_EN
  logic [TAG_W-1:0] ptr_q, ptr_d;
  assign ptr_d = ptr_next;
  assign ptr   = ptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  logic [TAG_W-1:0] unused_ptr_next;
  assign unused_ptr_next = ptr_next;
  assign ptr             = '0;
`endif

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = TAG_W'(i);
    end
  end

  assign mul_a = req_a[int'(grant_idx)*N +: N];
  assign mul_b = req_b[int'(grant_idx)*N +: N];

  // Tag pipeline advances in lockstep with the multiplier enable.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (mul_en) begin
      valid_d[0] = handshake;
      tag_d[0]   = grant_idx;
      for (int i = 1; i < MUL_LAT; i++) begin
        valid_d[i] = valid_q[i-1];
        tag_d[i]   = tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (out_valid) rsp_valid[out_tag] = 1'b1;
  end

  assign rsp_data      = mul_result;
  assign rsp_overflow  = mul_overflow;
  assign rsp_exception = mul_exception;
  assign busy          = |valid_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a behavioural two-stage FP multiplier.
module tb_fp_mul_arbiter;

  localparam int unsigned N  = 32;
  localparam int unsigned NR = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*N-1:0] req_a, req_b;
  logic [N-1:0]    rsp_data, mul_a, mul_b, mul_result;
  logic            rsp_overflow, rsp_exception, mul_en, mul_overflow, mul_exception, busy;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  fp_mul_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_overflow  (rsp_overflow),
    .rsp_exception (rsp_exception),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_en        (mul_en),
    .mul_result    (mul_result),
    .mul_overflow  (mul_overflow),
    .mul_exception (mul_exception),
    .busy          (busy)
  );

  // Truncating single-precision multiply; returns {exception, overflow, result}.
  function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {2'b10, 32'h7FC00000};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {2'b00, s, 31'h0};
    p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {2'b01, s, 8'hFF, 23'h0};
    if (e <= 0) return {2'b00, s, 31'h0};
    return {2'b00, s, e[7:0], m};
  endfunction

  logic [31:0] s1_a, s1_b;
  logic [33:0] s2;
  always @(posedge clk) begin
    if (mul_en) begin
      s1_a <= mul_a;
      s1_b <= mul_b;
      s2   <= fmul(s1_a, s1_b);
    end
  end
  assign mul_result    = s2[31:0];
  assign mul_overflow  = s2[32];
  assign mul_exception = s2[33];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b);
    req_a[idx*N +: N] = a;
    req_b[idx*N +: N] = b;
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_ovf;
    logic        exp_exc;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] prod2[4];
  logic [3:0]  exp6[4];
  logic [3:0]  one_hot;

  initial begin
    vecs[0] = '{1, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0};
    vecs[1] = '{0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0};
    vecs[2] = '{2, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0};
    vecs[3] = '{0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0};
    vecs[4] = '{1, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1};
    vecs[5] = '{3, 32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0};
    prod2   = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
`ifdef FP_ARB_FIXED_PRIO_EN
    exp6    = '{4'b0001, 4'b0001, 4'b0001, 4'b1000};
`else
    exp6    = '{4'b1000, 4'b0001, 4'b1000, 4'b1000};
`endif

    reset     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    req_a     = '0;
    req_b     = '0;
    cyc();
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_mul_en", 32'(mul_en), 32'h1);
    chk("reset_busy", 32'(busy), 32'h0);
    cyc();
    reset     = 1'b1;
    req_valid = '0;

    // Single-op vectors: issue, verify latency, data and flags.
    for (int v = 0; v < 6; v++) begin
      cyc();
      one_hot   = 4'(1) << vecs[v].idx;
      req_valid = one_hot;
      set_op(vecs[v].idx, vecs[v].a, vecs[v].b);
      @(negedge clk);
      chk($sformatf("v%0d_req_ready", v), 32'(req_ready), 32'(one_hot));
      cyc();
      req_valid = '0;
      @(negedge clk);
      chk($sformatf("v%0d_rsp_early", v), 32'(rsp_valid), 32'h0);
      cyc();
      @(negedge clk);
      chk($sformatf("v%0d_rsp_valid", v), 32'(rsp_valid), 32'(one_hot));
      chk($sformatf("v%0d_rsp_data", v), rsp_data, vecs[v].exp_data);
      chk($sformatf("v%0d_rsp_ovf", v), 32'(rsp_overflow), 32'(vecs[v].exp_ovf));
      chk($sformatf("v%0d_rsp_exc", v), 32'(rsp_exception), 32'(vecs[v].exp_exc));
    end

    // All four requesters streaming: round-robin order at full throughput.
    for (int i = 0; i < 4; i++) set_op(i, 32'h40000000, 32'h3F800000 + (32'(i + 1) << 0));
    set_op(0, 32'h40000000, 32'h3F800000);
    set_op(1, 32'h40000000, 32'h40000000);
    set_op(2, 32'h40000000, 32'h40400000);
    set_op(3, 32'h40000000, 32'h40800000);
    for (int j = 0; j < 10; j++) begin
      cyc();
      req_valid = (j < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      if (j < 8) chk($sformatf("rr_grant%0d", j), 32'(req_ready), 32'(4'(1) << (j % 4)));
      if (j >= 1) chk($sformatf("rr_busy%0d", j), 32'(busy), 32'h1);
      if (j >= 2) begin
        chk($sformatf("rr_rsp%0d", j), 32'(rsp_valid), 32'(4'(1) << ((j - 2) % 4)));
        chk($sformatf("rr_data%0d", j), rsp_data, prod2[(j - 2) % 4]);
      end
    end

    // Backpressure on requester 0 freezes the multiplier and blocks issue.
    cyc();
    req_valid = 4'b0001;
    rsp_ready = 4'b1110;
    set_op(0, 32'h40400000, 32'h40400000);
    set_op(1, 32'h40000000, 32'h40800000);
    @(negedge clk);
    chk("bp_grant0", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 4'b0010;
    @(negedge clk);
    chk("bp_grant1", 32'(req_ready), 32'h2);
    for (int s = 0; s < 3; s++) begin
      cyc();
      req_valid = 4'hF;
      @(negedge clk);
      chk($sformatf("bp_mul_en%0d", s), 32'(mul_en), 32'h0);
      chk($sformatf("bp_req_ready%0d", s), 32'(req_ready), 32'h0);
      chk($sformatf("bp_rsp_valid%0d", s), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp_data%0d", s), rsp_data, 32'h41100000);
    end
    cyc();
    req_valid = '0;
    rsp_ready = 4'hF;
    @(negedge clk);
    chk("bp_rel_rsp0", 32'(rsp_valid), 32'h1);
    chk("bp_rel_data0", rsp_data, 32'h41100000);
    chk("bp_rel_mul_en", 32'(mul_en), 32'h1);
    cyc();
    @(negedge clk);
    chk("bp_rel_rsp1", 32'(rsp_valid), 32'h2);
    chk("bp_rel_data1", rsp_data, 32'h41000000);
    cyc();
    @(negedge clk);
    chk("bp_drain_rsp", 32'(rsp_valid), 32'h0);
    chk("bp_drain_busy", 32'(busy), 32'h0);

    // Reset with two operations in flight.
    cyc();
    req_valid = 4'b0100;
    @(negedge clk);
    chk("rst_grant2", 32'(req_ready), 32'h4);
    cyc();
    req_valid = 4'b1000;
    @(negedge clk);
    chk("rst_grant3", 32'(req_ready), 32'h8);
    cyc();
    req_valid = '0;
    reset     = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    cyc();
    reset     = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    chk("rst_first_grant", 32'(req_ready), 32'h1);
    cyc();
    req_valid = '0;
    cyc();
    cyc();

    // Requesters 0 and 3 contending, then requester 0 drops out.
    for (int c = 0; c < 4; c++) begin
      cyc();
      req_valid = (c < 3) ? 4'b1001 : 4'b1000;
      @(negedge clk);
      chk($sformatf("prio_grant%0d", c), 32'(req_ready), 32'(exp6[c]));
    end
    cyc();
    req_valid = '0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
